// File: rtl/branch_predictor_gshare.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare
//
// Next-fetch-address predictor. It combines a tagged BTB with per-entry N-bit
// saturating direction counters. Indexing can optionally be hashed with a
// global branch history (gshare).
//
// The fetch side is purely combinational. Given pc, the block returns next_pc,
// pred_taken, pred_hit and the history used (pred_ghr) in the same cycle.
//
// The training side is a two-stage pipeline:
//   - edge N   : the upd_* inputs are captured.
//   - edge N+1 : the table entry and the global history are written.
//
// After reset, a self-timed sweep clears every entry before ready rises.
//
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high reset; restarts the init sweep
//   pc         : fetch address to predict
//   next_pc    : predicted next fetch address
//   pred_taken : prediction is taken
//   pred_hit   : tag hit on a valid entry
//   pred_ghr   : history used for this prediction (0 when HISTORY_WIDTH=0)
//   ready      : init sweep finished, predictor active
//   upd_valid  : update strobe
//   upd_pc     : pc of the resolved instruction
//   upd_is_br  : resolved instruction is a branch/jump
//   upd_taken  : resolved direction
//   upd_target : resolved taken target
//   upd_ghr    : pred_ghr value that travelled with the instruction
// -----------------------------------------------------------------------------
module branch_predictor_gshare #(
    parameter int INDEX_WIDTH   = 10,
    parameter int TAG_WIDTH     = 20,
    parameter int COUNTER_WIDTH = 2,
    parameter int HISTORY_WIDTH = 0,
    localparam int GW = (HISTORY_WIDTH > 0) ? HISTORY_WIDTH : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc,
    output logic [31:0]   next_pc,
    output logic          pred_taken,
    output logic          pred_hit,
    output logic [GW-1:0] pred_ghr,
    output logic          ready,
    input  logic          upd_valid,
    input  logic [31:0]   upd_pc,
    input  logic          upd_is_br,
    input  logic          upd_taken,
    input  logic [31:0]   upd_target,
    input  logic [GW-1:0] upd_ghr
);

    localparam int DEPTH  = 1 << INDEX_WIDTH;
    localparam int TAG_LO = INDEX_WIDTH + 2;
    localparam int TAG_HI = INDEX_WIDTH + 2 + TAG_WIDTH - 1;

    localparam logic [COUNTER_WIDTH-1:0] CTR_WT  = COUNTER_WIDTH'(1 << (COUNTER_WIDTH - 1));
    localparam logic [COUNTER_WIDTH-1:0] CTR_WNT = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
    localparam logic [COUNTER_WIDTH-1:0] CTR_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CTR_MIN = {COUNTER_WIDTH{1'b0}};

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Saturating counter step: holds at all-ones going up and at zero going down.
    function automatic logic [COUNTER_WIDTH-1:0] ctr_step(
        input logic [COUNTER_WIDTH-1:0] ctr,
        input logic                     up
    );
        logic [COUNTER_WIDTH-1:0] res;
        if (up) begin
            if (ctr == CTR_MAX) begin
                res = ctr;
            end else begin
                res = ctr + COUNTER_WIDTH'(1);
            end
        end else begin
            if (ctr == CTR_MIN) begin
                res = ctr;
            end else begin
                res = ctr - COUNTER_WIDTH'(1);
            end
        end
        return res;
    endfunction

    // Prediction tables. Targets are never cleared; they are meaningless
    // while the matching valid bit is 0.
    logic                     valid_q  [0:DEPTH-1];
    logic [TAG_WIDTH-1:0]     tag_q    [0:DEPTH-1];
    logic [COUNTER_WIDTH-1:0] ctr_q    [0:DEPTH-1];
    logic [31:0]              target_q [0:DEPTH-1];

    // Control state
    logic [0:0]             state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [GW-1:0]          ghr_q, ghr_d;

    // Registered update stage
    logic          upd_valid_q, upd_valid_d;
    logic [31:0]   upd_pc_q, upd_pc_d;
    logic          upd_is_br_q, upd_is_br_d;
    logic          upd_taken_q, upd_taken_d;
    logic [31:0]   upd_target_q, upd_target_d;
    logic [GW-1:0] upd_ghr_q, upd_ghr_d;

    // Fetch-side combinational signals
    logic                   run_s;
    logic [INDEX_WIDTH-1:0] ghr_ext_s;
    logic [INDEX_WIDTH-1:0] fetch_idx_s;
    logic [TAG_WIDTH-1:0]   fetch_tag_s;
    logic [31:0]            pc_plus4_s;
    logic                   pred_hit_s;
    logic                   pred_taken_s;
    logic [31:0]            next_pc_s;

    // Table write port, shared by the init sweep and the update stage
    logic [INDEX_WIDTH-1:0]   upd_ghr_ext_s;
    logic [INDEX_WIDTH-1:0]   uidx_s;
    logic [TAG_WIDTH-1:0]     utag_s;
    logic                     uhit_s;
    logic                     wr_en_s;
    logic [INDEX_WIDTH-1:0]   wr_idx_s;
    logic                     wr_valid_s;
    logic [TAG_WIDTH-1:0]     wr_tag_s;
    logic [COUNTER_WIDTH-1:0] wr_ctr_s;
    logic                     wr_tgt_en_s;
    logic [31:0]              wr_tgt_s;

    // Address bits outside index/tag and history that may be unused in
    // bimodal builds.
    logic unused_s;
    assign unused_s = ^{pc, upd_pc_q, upd_ghr_q, ghr_q};

    // Fetch-side prediction; forced to a miss while sweeping or in reset.
    always_comb begin
        run_s       = (state_q == ST_RUN) && !reset;
        ghr_ext_s   = (HISTORY_WIDTH > 0) ? INDEX_WIDTH'(ghr_q) : {INDEX_WIDTH{1'b0}};
        fetch_idx_s = pc[INDEX_WIDTH+1:2] ^ ghr_ext_s;
        fetch_tag_s = pc[TAG_HI:TAG_LO];
        pc_plus4_s  = pc + 32'd4;
        if (run_s) begin
            pred_hit_s   = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
            pred_taken_s = pred_hit_s && ctr_q[fetch_idx_s][COUNTER_WIDTH-1];
        end else begin
            pred_hit_s   = 1'b0;
            pred_taken_s = 1'b0;
        end
        if (pred_taken_s) begin
            next_pc_s = target_q[fetch_idx_s];
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    assign next_pc    = next_pc_s;
    assign pred_taken = pred_taken_s;
    assign pred_hit   = pred_hit_s;
    assign pred_ghr   = ghr_q;
    assign ready      = (state_q == ST_RUN);

    // Update capture. Strobes arriving while not yet running are dropped.
    always_comb begin
        upd_valid_d  = upd_valid && (state_q == ST_RUN);
        upd_pc_d     = upd_pc;
        upd_is_br_d  = upd_is_br;
        upd_taken_d  = upd_taken;
        upd_target_d = upd_target;
        upd_ghr_d    = upd_ghr;
    end

    // Table write selection. The update path reads the live table, so
    // back-to-back updates to one entry accumulate.
    always_comb begin
        upd_ghr_ext_s = (HISTORY_WIDTH > 0) ? INDEX_WIDTH'(upd_ghr_q) : {INDEX_WIDTH{1'b0}};
        uidx_s        = upd_pc_q[INDEX_WIDTH+1:2] ^ upd_ghr_ext_s;
        utag_s        = upd_pc_q[TAG_HI:TAG_LO];
        uhit_s        = valid_q[uidx_s] && (tag_q[uidx_s] == utag_s);
        wr_en_s       = 1'b0;
        wr_idx_s      = uidx_s;
        wr_valid_s    = 1'b0;
        wr_tag_s      = tag_q[uidx_s];
        wr_ctr_s      = CTR_WNT;
        wr_tgt_en_s   = 1'b0;
        wr_tgt_s      = upd_target_q;
        if (reset) begin
            wr_en_s = 1'b0;
        end else if (state_q == ST_INIT) begin
            wr_en_s    = 1'b1;
            wr_idx_s   = ptr_q;
            wr_valid_s = 1'b0;
            wr_tag_s   = tag_q[ptr_q];
            wr_ctr_s   = CTR_WNT;
        end else if (upd_valid_q) begin
            wr_en_s     = 1'b1;
            wr_tgt_en_s = upd_taken_q;
            if (!upd_is_br_q) begin
                // A non-branch aliased into this slot: forget it.
                wr_valid_s = 1'b0;
                wr_ctr_s   = CTR_WNT;
            end else if (uhit_s) begin
                wr_valid_s = 1'b1;
                wr_tag_s   = utag_s;
                wr_ctr_s   = ctr_step(ctr_q[uidx_s], upd_taken_q);
            end else begin
                wr_valid_s = 1'b1;
                wr_tag_s   = utag_s;
                if (upd_taken_q) begin
                    wr_ctr_s = CTR_WT;
                end else begin
                    wr_ctr_s = CTR_WNT;
                end
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state for the sweep FSM, the sweep pointer and the global history.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + INDEX_WIDTH'(1);
                if (ptr_q == {INDEX_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                if ((HISTORY_WIDTH > 0) && upd_valid_q && upd_is_br_q) begin
                    ghr_d = (ghr_q << 1'b1) | GW'(upd_taken_q);
                end else begin
                    ghr_d = ghr_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control registers with synchronous reset into the init sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            ptr_q       <= {INDEX_WIDTH{1'b0}};
            ghr_q       <= {GW{1'b0}};
            upd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ghr_q       <= ghr_d;
            upd_valid_q <= upd_valid_d;
        end
    end

    // Update payload; only meaningful when upd_valid_q is set.
    always_ff @(posedge clk) begin
        upd_pc_q     <= upd_pc_d;
        upd_is_br_q  <= upd_is_br_d;
        upd_taken_q  <= upd_taken_d;
        upd_target_q <= upd_target_d;
        upd_ghr_q    <= upd_ghr_d;
    end

    // Table write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            valid_q[wr_idx_s] <= wr_valid_s;
            tag_q[wr_idx_s]   <= wr_tag_s;
            ctr_q[wr_idx_s]   <= wr_ctr_s;
        end
        if (wr_en_s && wr_tgt_en_s) begin
            target_q[wr_idx_s] <= wr_tgt_s;
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: one bimodal instance (IW=4, HW=0) and one gshare instance
// (IW=4, HW=4) sharing clock and reset.
module tb_branch_predictor_gshare;

    logic        clk;
    logic        reset;
    int          total;
    int          bad;
    int          cnt;

    // Bimodal instance signals
    logic [31:0] b_pc, b_next_pc, b_upd_pc, b_upd_target;
    logic        b_pred_taken, b_pred_hit, b_ready;
    logic        b_upd_valid, b_upd_is_br, b_upd_taken;
    logic [0:0]  b_pred_ghr, b_upd_ghr;

    // Gshare instance signals
    logic [31:0] g_pc, g_next_pc, g_upd_pc, g_upd_target;
    logic        g_pred_taken, g_pred_hit, g_ready;
    logic        g_upd_valid, g_upd_is_br, g_upd_taken;
    logic [3:0]  g_pred_ghr, g_upd_ghr;

    branch_predictor_gshare #(
        .INDEX_WIDTH(4), .TAG_WIDTH(20), .COUNTER_WIDTH(2), .HISTORY_WIDTH(0)
    ) u_bim (
        .clk(clk), .reset(reset), .pc(b_pc), .next_pc(b_next_pc),
        .pred_taken(b_pred_taken), .pred_hit(b_pred_hit), .pred_ghr(b_pred_ghr),
        .ready(b_ready), .upd_valid(b_upd_valid), .upd_pc(b_upd_pc),
        .upd_is_br(b_upd_is_br), .upd_taken(b_upd_taken),
        .upd_target(b_upd_target), .upd_ghr(b_upd_ghr)
    );

    branch_predictor_gshare #(
        .INDEX_WIDTH(4), .TAG_WIDTH(20), .COUNTER_WIDTH(2), .HISTORY_WIDTH(4)
    ) u_gsh (
        .clk(clk), .reset(reset), .pc(g_pc), .next_pc(g_next_pc),
        .pred_taken(g_pred_taken), .pred_hit(g_pred_hit), .pred_ghr(g_pred_ghr),
        .ready(g_ready), .upd_valid(g_upd_valid), .upd_pc(g_upd_pc),
        .upd_is_br(g_upd_is_br), .upd_taken(g_upd_taken),
        .upd_target(g_upd_target), .upd_ghr(g_upd_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_update(input logic [31:0] p, input logic br, input logic tk,
                            input logic [31:0] tgt);
        b_upd_valid = 1'b1; b_upd_pc = p; b_upd_is_br = br;
        b_upd_taken = tk; b_upd_target = tgt; b_upd_ghr = 1'b0;
        tick();
        b_upd_valid = 1'b0;
        tick();
    endtask

    task automatic g_update(input logic [31:0] p, input logic br, input logic tk,
                            input logic [31:0] tgt, input logic [3:0] gh);
        g_upd_valid = 1'b1; g_upd_pc = p; g_upd_is_br = br;
        g_upd_taken = tk; g_upd_target = tgt; g_upd_ghr = gh;
        tick();
        g_upd_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_b: got %b want 0", b_ready); end
        total++; if (g_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_g: got %b want 0", g_ready); end
        total++; if (g_pred_ghr !== 4'h0) begin bad++; $display("FAIL rst_ghr: got %h want 0", g_pred_ghr); end
        b_pc = 32'h100; #1;
        total++; if (b_pred_hit !== 1'b0) begin bad++; $display("FAIL init_hit: got %b want 0", b_pred_hit); end
        total++; if (b_next_pc !== 32'h104) begin bad++; $display("FAIL init_npc: got %h want 00000104", b_next_pc); end
        // Updates offered during the sweep must be dropped.
        b_upd_valid = 1'b1; b_upd_pc = 32'h100; b_upd_is_br = 1'b1;
        b_upd_taken = 1'b1; b_upd_target = 32'h200; b_upd_ghr = 1'b0;
        cnt = 0;
        while (b_ready !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        b_upd_valid = 1'b0;
        total++; if (cnt !== 16) begin bad++; $display("FAIL sweep_len: got %0d want 16", cnt); end
        total++; if (g_ready !== 1'b1) begin bad++; $display("FAIL ready_g: got %b want 1", g_ready); end
        tick(); tick();
        b_pc = 32'h100; #1;
        total++; if (b_pred_hit !== 1'b0) begin bad++; $display("FAIL init_drop_hit: got %b want 0", b_pred_hit); end
        total++; if (b_next_pc !== 32'h104) begin bad++; $display("FAIL init_drop_npc: got %h want 00000104", b_next_pc); end
    endtask

    task automatic test_train();
        b_update(32'h100, 1'b1, 1'b1, 32'h200);
        b_pc = 32'h100; #1;
        total++; if (b_pred_hit !== 1'b1) begin bad++; $display("FAIL train_hit: got %b want 1", b_pred_hit); end
        total++; if (b_pred_taken !== 1'b1) begin bad++; $display("FAIL train_tk: got %b want 1", b_pred_taken); end
        total++; if (b_next_pc !== 32'h200) begin bad++; $display("FAIL train_npc: got %h want 00000200", b_next_pc); end
        b_update(32'h100, 1'b1, 1'b0, 32'h300);
        b_pc = 32'h100; #1;
        total++; if (b_pred_hit !== 1'b1) begin bad++; $display("FAIL nt_hit: got %b want 1", b_pred_hit); end
        total++; if (b_pred_taken !== 1'b0) begin bad++; $display("FAIL nt_tk: got %b want 0", b_pred_taken); end
        total++; if (b_next_pc !== 32'h104) begin bad++; $display("FAIL nt_npc: got %h want 00000104", b_next_pc); end
    endtask

    task automatic test_saturation();
        // counter 01 -> 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 4; i++) b_update(32'h100, 1'b1, 1'b1, 32'h200);
        // 11 -> 10; not-taken target must not overwrite
        b_update(32'h100, 1'b1, 1'b0, 32'h300);
        b_pc = 32'h100; #1;
        total++; if (b_pred_taken !== 1'b1) begin bad++; $display("FAIL sat_hi_tk: got %b want 1", b_pred_taken); end
        total++; if (b_next_pc !== 32'h200) begin bad++; $display("FAIL sat_hi_npc: got %h want 00000200", b_next_pc); end
        // 10 -> 01 -> 00 -> 00 -> 00
        for (int i = 0; i < 4; i++) b_update(32'h100, 1'b1, 1'b0, 32'h300);
        b_pc = 32'h100; #1;
        total++; if (b_pred_taken !== 1'b0) begin bad++; $display("FAIL sat_lo_tk: got %b want 0", b_pred_taken); end
        total++; if (b_pred_hit !== 1'b1) begin bad++; $display("FAIL sat_lo_hit: got %b want 1", b_pred_hit); end
        // 00 -> 01: still not taken (no wrap at the bottom)
        b_update(32'h100, 1'b1, 1'b1, 32'h200);
        b_pc = 32'h100; #1;
        total++; if (b_pred_taken !== 1'b0) begin bad++; $display("FAIL sat_lo_hold: got %b want 0", b_pred_taken); end
        // 01 -> 10
        b_update(32'h100, 1'b1, 1'b1, 32'h200);
        b_pc = 32'h100; #1;
        total++; if (b_next_pc !== 32'h200) begin bad++; $display("FAIL sat_recover: got %h want 00000200", b_next_pc); end
    endtask

    task automatic test_alias();
        b_pc = 32'h140; #1;
        total++; if (b_pred_hit !== 1'b0) begin bad++; $display("FAIL alias_hit: got %b want 0", b_pred_hit); end
        total++; if (b_next_pc !== 32'h144) begin bad++; $display("FAIL alias_npc: got %h want 00000144", b_next_pc); end
        b_update(32'h100, 1'b0, 1'b0, 32'h0);
        b_pc = 32'h100; #1;
        total++; if (b_pred_hit !== 1'b0) begin bad++; $display("FAIL nonbr_hit: got %b want 0", b_pred_hit); end
        total++; if (b_next_pc !== 32'h104) begin bad++; $display("FAIL nonbr_npc: got %h want 00000104", b_next_pc); end
    endtask

    task automatic test_no_bypass();
        b_pc = 32'h100;
        b_upd_valid = 1'b1; b_upd_pc = 32'h100; b_upd_is_br = 1'b1;
        b_upd_taken = 1'b1; b_upd_target = 32'h220;
        tick();                      // capture edge
        b_upd_valid = 1'b0; #1;
        total++; if (b_pred_hit !== 1'b0) begin bad++; $display("FAIL bypass_hit: got %b want 0", b_pred_hit); end
        tick();                      // write edge
        total++; if (b_next_pc !== 32'h220) begin bad++; $display("FAIL after_wr_npc: got %h want 00000220", b_next_pc); end
    endtask

    task automatic test_back_to_back();
        // 0x104: allocate taken (10), not-taken (01), not-taken (00) on consecutive edges
        b_upd_valid = 1'b1; b_upd_pc = 32'h104; b_upd_is_br = 1'b1;
        b_upd_taken = 1'b1; b_upd_target = 32'h240;
        tick();
        b_upd_taken = 1'b0;
        tick();
        tick();
        b_upd_valid = 1'b0;
        tick();
        b_pc = 32'h104; #1;
        total++; if (b_pred_hit !== 1'b1) begin bad++; $display("FAIL b2b_hit: got %b want 1", b_pred_hit); end
        total++; if (b_pred_taken !== 1'b0) begin bad++; $display("FAIL b2b_tk: got %b want 0", b_pred_taken); end
        // 00 -> 01 stays not-taken only if no step was lost
        b_update(32'h104, 1'b1, 1'b1, 32'h240);
        b_pc = 32'h104; #1;
        total++; if (b_pred_taken !== 1'b0) begin bad++; $display("FAIL b2b_cum: got %b want 0", b_pred_taken); end
    endtask

    task automatic test_gshare();
        total++; if (g_pred_ghr !== 4'h0) begin bad++; $display("FAIL gsh_ghr0: got %h want 0", g_pred_ghr); end
        g_update(32'h400, 1'b1, 1'b1, 32'h500, 4'h0);
        g_update(32'h400, 1'b1, 1'b1, 32'h500, 4'h0);
        g_update(32'h400, 1'b1, 1'b0, 32'h600, 4'h0);
        total++; if (g_pred_ghr !== 4'b0110) begin bad++; $display("FAIL gsh_ghr: got %b want 0110", g_pred_ghr); end
        g_pc = 32'h100; #1;
        total++; if (g_pred_hit !== 1'b0) begin bad++; $display("FAIL gsh_idx6_miss: got %b want 0", g_pred_hit); end
        // 0x418: index 6 XOR 0110 = entry 0, trained with tag 0x10
        g_pc = 32'h418; #1;
        total++; if (g_next_pc !== 32'h500) begin bad++; $display("FAIL gsh_xor_npc: got %h want 00000500", g_next_pc); end
        g_update(32'h100, 1'b1, 1'b1, 32'h280, 4'b0110);
        total++; if (g_pred_ghr !== 4'b1101) begin bad++; $display("FAIL gsh_ghr2: got %b want 1101", g_pred_ghr); end
        // 0x12C: index 0xB XOR 1101 = entry 6, tag 4
        g_pc = 32'h12C; #1;
        total++; if (g_next_pc !== 32'h280) begin bad++; $display("FAIL gsh_e6_npc: got %h want 00000280", g_next_pc); end
        tick();
        g_pc = 32'h100; #1;
        total++; if (g_next_pc !== 32'h104) begin bad++; $display("FAIL gsh_idxD_npc: got %h want 00000104", g_next_pc); end
        g_update(32'h100, 1'b0, 1'b1, 32'h0, 4'b0110);
        total++; if (g_pred_ghr !== 4'b1101) begin bad++; $display("FAIL gsh_nonbr_ghr: got %b want 1101", g_pred_ghr); end
        g_pc = 32'h12C; #1;
        total++; if (g_next_pc !== 32'h130) begin bad++; $display("FAIL gsh_inval_npc: got %h want 00000130", g_next_pc); end
    endtask

    task automatic test_reset_run();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rerun_ready: got %b want 0", b_ready); end
        for (int i = 0; i < 5; i++) tick();
        // Reset mid-sweep restarts the sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        while (b_ready !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        total++; if (cnt !== 16) begin bad++; $display("FAIL resweep_len: got %0d want 16", cnt); end
        total++; if (g_pred_ghr !== 4'h0) begin bad++; $display("FAIL rerun_ghr: got %h want 0", g_pred_ghr); end
        b_pc = 32'h104; #1;
        total++; if (b_pred_hit !== 1'b0) begin bad++; $display("FAIL rerun_hit104: got %b want 0", b_pred_hit); end
        g_pc = 32'h400; #1;
        total++; if (g_next_pc !== 32'h404) begin bad++; $display("FAIL rerun_g_npc: got %h want 00000404", g_next_pc); end
        tick();
        b_pc = 32'hFFFF_FFFC; #1;
        total++; if (b_next_pc !== 32'h0) begin bad++; $display("FAIL wrap_npc: got %h want 00000000", b_next_pc); end
    endtask

    initial begin
        total = 0; bad = 0; cnt = 0;
        reset = 1'b1;
        b_pc = 32'h0; b_upd_valid = 1'b0; b_upd_pc = 32'h0; b_upd_is_br = 1'b0;
        b_upd_taken = 1'b0; b_upd_target = 32'h0; b_upd_ghr = 1'b0;
        g_pc = 32'h0; g_upd_valid = 1'b0; g_upd_pc = 32'h0; g_upd_is_br = 1'b0;
        g_upd_taken = 1'b0; g_upd_target = 32'h0; g_upd_ghr = 4'h0;
        test_reset();
        test_train();
        test_saturation();
        test_alias();
        test_no_bypass();
        test_back_to_back();
        test_gshare();
        test_reset_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
